// File: rtl/awg_wave_gen.sv
// awg_wave_gen: phase-accumulator waveform generator feeding an 8-bit DAC.
//
// A divider turns ref_clk into sample ticks. On each tick the 16-bit phase
// advances by the active increment. The top phase byte selects a raw waveform
// value, which is then scaled by the active amplitude around mid-scale (128).
// New configurations go through a one-deep pending slot and are switched in
// only at a phase wrap, so every period is produced with a single config.
//
// Ports:
//   ref_clk       system clock (only clock)
//   rst           synchronous, active-high reset
//   cfg_valid     configuration offered
//   cfg_ready     configuration slot free
//   cfg_shape     0 square, 1 saw, 2 triangle, 3 sine
//   cfg_inc       phase increment per tick
//   cfg_amp       amplitude scale 0..255
//   sample        unsigned 8-bit output sample (held between pulses)
//   sample_valid  one-cycle pulse per new sample
//   period_end    with sample_valid, that sample's tick wrapped the phase
module awg_wave_gen #(
    parameter int unsigned SAMPLE_DIV  = 1,
    parameter int unsigned PHASE_WIDTH = 16
) (
    input  logic        ref_clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_shape,
    input  logic [15:0] cfg_inc,
    input  logic [7:0]  cfg_amp,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic        period_end
);

    localparam int STAGES = 2;
    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    typedef struct packed {
        logic [1:0]  shape;
        logic [15:0] inc;
        logic [7:0]  amp;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{shape: 2'd0, inc: 16'h0100, amp: 8'd255};

    // Sine table built at elaboration with 64-bit fixed point (2^30 scale)
    // Taylor series on the folded first-quadrant angle.
    function automatic logic [7:0] sine_val(input int p);
        longint m, x, x2, term, sum, r;
        m = longint'(p % 128);
        if (m > 64'sd64) m = 64'sd128 - m;
        x    = m * 64'sd26353589;           // pi * 2^23 -> angle * 2^30
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        r = (64'sd127 * sum + 64'sd536870912) >>> 30;
        return (p >= 128) ? 8'(64'sd128 - r) : 8'(64'sd128 + r);
    endfunction

    logic [7:0] sine_rom [256];
    for (genvar g = 0; g < 256; g++) begin : g_rom
        localparam logic [7:0] V = sine_val(g);
        assign sine_rom[g] = V;
    end

    logic [15:0]            div_cnt;
    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH:0]   phase_sum;
    logic                   tick;
    logic [STAGES:1]        vld_pipe;
    cfg_t                   act, pend;
    logic                   pend_vld;
    logic [7:0]             p, w, w_q, amp_q;
    logic                   wrap_q;
    logic signed [8:0]      s;
    logic signed [17:0]     prod;

    assign tick      = (div_cnt == DIV_LAST);
    assign phase_sum = {1'b0, phase} + {1'b0, act.inc};
    assign p         = phase[PHASE_WIDTH-1 -: 8];
    assign cfg_ready = ~pend_vld;

    always_comb begin
        w = 8'd0;
        case (act.shape)
            2'd0: w = p[7] ? 8'd0 : 8'd255;
            2'd1: w = p;
            2'd2: w = p[7] ? 8'(9'd510 - {p, 1'b0}) : {p[6:0], 1'b0};
            2'd3: w = sine_rom[p];
            default: w = 8'd0;
        endcase
    end

    // prod[15:8] is floor(prod/256) modulo 256; adding 128 lands in 0..254.
    assign s    = $signed({1'b0, w_q}) - 9'sd128;
    assign prod = s * $signed({2'b00, amp_q});

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            div_cnt    <= '0;
            phase      <= '0;
            vld_pipe   <= '0;
            act        <= CFG_DEFAULT;
            pend       <= CFG_DEFAULT;
            pend_vld   <= 1'b0;
            w_q        <= '0;
            amp_q      <= '0;
            wrap_q     <= 1'b0;
            sample     <= 8'h80;
            period_end <= 1'b0;
        end else begin
            div_cnt  <= tick ? 16'd0 : div_cnt + 16'd1;
            vld_pipe <= {vld_pipe[1], tick};
            if (tick) begin
                phase  <= phase_sum[PHASE_WIDTH-1:0];
                w_q    <= w;
                amp_q  <= act.amp;              // amplitude belongs to this tick
                wrap_q <= phase_sum[PHASE_WIDTH];
            end
            if (vld_pipe[1]) sample <= prod[15:8] + 8'd128;
            period_end <= vld_pipe[1] & wrap_q;
            // Accept and activate are exclusive: accept needs an empty slot.
            if (cfg_valid && cfg_ready) begin
                pend     <= '{shape: cfg_shape, inc: cfg_inc, amp: cfg_amp};
                pend_vld <= 1'b1;
            end else if (pend_vld && tick && (phase_sum[PHASE_WIDTH] || act.inc == '0)) begin
                act      <= pend;
                pend_vld <= 1'b0;
            end
        end
    end

    assign sample_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_awg_wave_gen.sv
module tb_awg_wave_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cfg_valid, cfg_ready, sample_valid, period_end;
    logic [1:0] cfg_shape;
    logic [15:0] cfg_inc;
    logic [7:0] cfg_amp, sample;

    logic rst4, c4_valid, ready4, valid4, pe4;
    logic [1:0] c4_shape;
    logic [15:0] c4_inc;
    logic [7:0] c4_amp, sample4;

    awg_wave_gen #(.SAMPLE_DIV(1)) dut (
        .ref_clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_shape(cfg_shape), .cfg_inc(cfg_inc), .cfg_amp(cfg_amp),
        .sample(sample), .sample_valid(sample_valid), .period_end(period_end));

    awg_wave_gen #(.SAMPLE_DIV(4)) dut4 (
        .ref_clk(clk), .rst(rst4), .cfg_valid(c4_valid), .cfg_ready(ready4),
        .cfg_shape(c4_shape), .cfg_inc(c4_inc), .cfg_amp(c4_amp),
        .sample(sample4), .sample_valid(valid4), .period_end(pe4));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: spec arithmetic on plain ints.
    function automatic int floordiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int sine_ref(input int p);
        real r;
        r = 128.0 + 127.0 * $sin(2.0 * 3.141592653589793 * p / 256.0);
        return $rtoi(r + 0.5);
    endfunction

    function automatic int ref_sample(input int shape, input int amp, input int p);
        int w;
        case (shape)
            0: w = (p < 128) ? 255 : 0;
            1: w = p;
            2: w = (p < 128) ? 2 * p : 510 - 2 * p;
            default: w = sine_ref(p);
        endcase
        return 128 + floordiv((w - 128) * amp, 256);
    endfunction

    int m_shape, m_inc, m_amp, p_shape, p_inc, p_amp, m_phase, m_sample, e_smp;
    bit m_pend, e_vld, e_pe;

    // One clock cycle: advance the model with the current inputs, clock, compare.
    task automatic cyc();
        int pp, nsum;
        bit wrap, o_vld, o_pe;
        if (rst) begin
            m_shape = 0; m_inc = 'h100; m_amp = 255; m_pend = 0; m_phase = 0;
            e_vld = 0; m_sample = 128; o_vld = 0; o_pe = 0;
        end else begin
            o_vld = e_vld;
            o_pe  = e_vld && e_pe;
            if (e_vld) m_sample = e_smp;
            pp      = m_phase / 256;
            e_smp   = ref_sample(m_shape, m_amp, pp);
            nsum    = m_phase + m_inc;
            wrap    = (nsum >= 65536);
            m_phase = nsum % 65536;
            e_vld   = 1;
            e_pe    = wrap;
            if (m_pend && (wrap || m_inc == 0)) begin
                m_shape = p_shape; m_inc = p_inc; m_amp = p_amp; m_pend = 0;
            end else if (cfg_valid && !m_pend) begin
                m_pend = 1; p_shape = cfg_shape; p_inc = cfg_inc; p_amp = cfg_amp;
            end
        end
        @(posedge clk); #1;
        chk("sample_valid", sample_valid, o_vld);
        chk("sample", sample, m_sample);
        chk("period_end", period_end, o_pe);
        chk("cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic send(input int shape, input int inc, input int amp);
        cfg_valid = 1; cfg_shape = 2'(shape); cfg_inc = 16'(inc); cfg_amp = 8'(amp);
        cyc();
        cfg_valid = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 600) begin cyc(); n++; end
        if (!cfg_ready) chk("ready_timeout", 0, 1);
    endtask

    typedef struct packed {
        logic [1:0]       shape;
        logic [7:0]       amp;
        logic [3:0][7:0]  exp;   // samples at p = 0, 64, 128, 192
    } vec_t;

    function automatic vec_t mk(input int sh, input int a, input int e0, input int e1,
                                input int e2, input int e3);
        vec_t v;
        v.shape = 2'(sh); v.amp = 8'(a);
        v.exp[0] = 8'(e0); v.exp[1] = 8'(e1); v.exp[2] = 8'(e2); v.exp[3] = 8'(e3);
        return v;
    endfunction

    vec_t tbl [8];

    initial begin
        tbl[0] = mk(0, 255, 254, 254,   0,   0);
        tbl[1] = mk(1, 255,   0,  64, 128, 191);
        tbl[2] = mk(2, 255,   0, 128, 253, 126);
        tbl[3] = mk(3, 255, 128, 254, 128,   1);
        tbl[4] = mk(3,   0, 128, 128, 128, 128);
        tbl[5] = mk(0,   0, 128, 128, 128, 128);
        tbl[6] = mk(0, 128, 191, 191,  64,  64);
        tbl[7] = mk(1, 128,  64,  96, 128, 160);

        rst = 1; cfg_valid = 0; cfg_shape = 0; cfg_inc = 0; cfg_amp = 0;
        rst4 = 1; c4_valid = 0; c4_shape = 0; c4_inc = 0; c4_amp = 0;
        cyc(); cyc();
        rst = 0;

        // First samples out of reset: default square at p=0.
        cyc();
        chk("first_valid_early", sample_valid, 0);
        cyc();
        chk("first_valid", sample_valid, 1);
        chk("first_sample", sample, 254);

        // Table: each config at inc 0x4000 so p walks 0,64,128,192.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].shape, 'h4000, tbl[i].amp);
            wait_ready();
            cyc();
            for (int j = 0; j < 4; j++) begin
                cyc();
                chk($sformatf("tbl%0d_p%0d", i, j * 64), sample, tbl[i].exp[j]);
            end
        end

        // Saw at inc 0x1000: 16-sample period, period_end on p=240.
        send(1, 'h1000, 255);
        chk("saw_ready_low", cfg_ready, 0);
        wait_ready();
        cyc();
        for (int j = 0; j < 16; j++) begin
            cyc();
            chk($sformatf("saw_%0d", j), sample, (j <= 8) ? 16 * j : 16 * j - 1);
            chk($sformatf("saw_pe_%0d", j), period_end, (j == 15) ? 1 : 0);
        end

        // Back-pressure: second offer while pending is dropped.
        send(0, 'h4000, 128);
        send(3, 'h0800, 255);
        chk("bp_ready_low", cfg_ready, 0);
        wait_ready();
        cyc();
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk($sformatf("bp_first_kept_%0d", j), sample, (j < 2) ? 191 : 64);
        end

        // inc_active==0: pending activates on the very next tick.
        send(1, 0, 255);
        wait_ready();
        send(2, 'h4000, 255);
        chk("inc0_ready_low", cfg_ready, 0);
        cyc();
        chk("inc0_activate", cfg_ready, 1);

        // Reset with a config pending and samples in flight.
        send(3, 'h0300, 200);
        cyc();
        rst = 1;
        cyc();
        chk("rst_valid", sample_valid, 0);
        chk("rst_sample", sample, 128);
        chk("rst_ready", cfg_ready, 1);
        rst = 0;
        cyc();
        chk("rst_release_no_valid", sample_valid, 0);
        cyc();
        chk("rst_default_valid", sample_valid, 1);
        chk("rst_default_sample", sample, 254);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_shape = 2'($urandom);
            case ($urandom_range(0, 3))
                0: cfg_inc = 16'($urandom);
                1: cfg_inc = 16'h0;
                2: cfg_inc = 16'($urandom_range(1, 255)) << 8;
                default: cfg_inc = 16'($urandom_range(0, 4095) + 16'hF000);
            endcase
            cfg_amp = 8'($urandom);
            cyc();
        end
        rst = 1; cfg_valid = 0;

        // SAMPLE_DIV=4 instance: pulse every 4 cycles, phase +1 per pulse.
        begin
            int npulse, last;
            npulse = 0; last = 0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst4 = 0;
            for (int c = 0; c <= 1100; c++) begin
                @(posedge clk); #1;
                if (valid4) begin
                    if (npulse == 0) chk("div4_first", c, 4);
                    else chk("div4_gap", c - last, 4);
                    chk("div4_sample", sample4, ((npulse % 256) < 128) ? 254 : 0);
                    chk("div4_pe", pe4, (npulse == 255) ? 1 : 0);
                    last = c;
                    npulse++;
                end
            end
            chk("div4_count", npulse, 275);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/awg_wave_gen.md
AWG_WAVE_GEN -- requirements
Module: awg_wave_gen

Interface
REQ-001 Parameter SAMPLE_DIV, default 1, sets ref_clk cycles per sample tick; legal range 1..65535.
REQ-002 Parameter PHASE_WIDTH, default 16, sets the phase accumulator width; fixed at 16 in this revision.
REQ-003 ref_clk  input  1  12 MHz system clock; the block's only clock.
REQ-004 rst  input  1  reset, synchronous to ref_clk, active-high.
REQ-005 cfg_valid  input  1  a new waveform configuration is presented.
REQ-006 cfg_ready  output  1  the block can accept a configuration.
REQ-007 cfg_shape  input  2  0 square, 1 saw, 2 triangle, 3 sine.
REQ-008 cfg_inc  input  16  phase increment per sample tick.
REQ-009 cfg_amp  input  8  amplitude scale, 0..255.
REQ-010 sample  output  8  unsigned sample for the downstream pmod/R-2R output stage.
REQ-011 sample_valid  output  1  one-cycle pulse marking a new sample.
REQ-012 period_end  output  1  pulses with sample_valid when that sample's tick caused a phase wrap.

Function
REQ-013 The tick divider shall count 0..SAMPLE_DIV-1 and wrap to 0; tick is high in the cycle where count==SAMPLE_DIV-1, so SAMPLE_DIV=1 gives a tick every cycle.
REQ-014 On a tick, phase <= phase + inc_active, modulo 2^16; carry-out defines a wrap.
REQ-015 p = phase[15:8] before the increment; raw value w: square -> 255 if p<128, else 0; saw -> p; triangle -> 2p if p<128, else 510-2p; sine -> ROM[p].
REQ-016 ROM[p] = round(128 + 127*sin(2*pi*p/256)), 256 entries fixed at elaboration, range 1..255.
REQ-017 Scaling: s = w-128 (signed 9-bit); sample = 128 + ((s*amp_active) arithmetic shift right by 8), floor rounding; the result is always in 0..254 and never overflows 8 bits.
REQ-018 Pipeline: tick in cycle T -> at the end of T, w and the wrap flag are registered -> at the end of T+1, sample, sample_valid=1 and period_end are registered; sample_valid is high only in cycle T+2.
REQ-019 sample shall hold its last value between sample_valid pulses.
REQ-020 Config handshake: a transfer occurs on a cycle with cfg_valid & cfg_ready; cfg_shape, cfg_inc and cfg_amp are captured into a pending register and cfg_ready drops the next cycle.
REQ-021 The pending config becomes active at the end of the first tick that wraps; if inc_active==0, it becomes active at the end of the next tick. cfg_ready rises the cycle after activation.
REQ-022 A newly activated config takes effect from the following tick; the wrapping tick itself uses the old shape, amplitude and increment.
REQ-023 cfg_valid while cfg_ready=0 shall be ignored; no second pending slot exists and the pending value is never overwritten.
REQ-024 A transfer and an activation in the same cycle cannot occur, because cfg_ready is 0 whenever a config is pending.

Reset
REQ-025 While rst=1, all state shall clear: divider=0, phase=0, pipeline valid flags=0, pending dropped.
REQ-026 Active config after reset: shape=0, inc=16'h0100, amp=255.
REQ-027 Output values after reset: sample=8'h80, sample_valid=0, period_end=0, cfg_ready=1.
REQ-028 Reset mid-operation, including with a config pending or samples in flight, shall discard all of them; no sample_valid occurs in the cycle after rst deasserts.

Verification
REQ-029 SAMPLE_DIV=1, release rst, no config -> first sample_valid 2 cycles after release with sample=254 (square, p=0); sample=0 from p=128 onward; period_end every 256 samples.
REQ-030 Load saw, inc=16'h1000, amp=255 -> cfg_ready=0 until the next wrap; afterwards the sample sequence is 0,16,32,...,239 repeating with period 16, and period_end accompanies the sample from p=240.
REQ-031 Triangle, amp=255 -> p=0 gives 0, p=64 gives 128, p=128 gives 253, p=192 gives 126; any shape with amp=0 gives constant 8'h80.
REQ-032 Back-pressure: a second cfg_valid while pending -> not accepted, first config applied unchanged, cfg_ready rises one cycle after activation; with inc_active=0, activation occurs on the next tick.
REQ-033 SAMPLE_DIV=4 -> sample_valid exactly every 4 cycles, phase advancing once per pulse.
REQ-034 rst asserted for 1 cycle with a config pending and a sample in flight -> no sample_valid, default config restored, cfg_ready=1 after release.
